ram_copy_dma: RTL and testbench

- Bus initiator that drives the on-chip word RAM port (byte write strobes, read strobe, 12-bit word address, 1-cycle registered read data, accept).
- Copies a block of 32-bit words from a source word address to a destination word address in the same RAM.
- Sits beside the CPU in the SoC and is arbitrated onto the RAM port. Software programs src/dst/len and pulses start.

---
 rtl/ram_copy_dma_pkg.sv | 18 +
 rtl/ram_copy_dma.sv | 122 ++++++++++++
 tb/tb_ram_copy_dma.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_copy_dma_pkg.sv
// Shared types and constants for the RAM-to-RAM word copy engine.
package ram_copy_dma_pkg;

   localparam int unsigned DefAw = 12;
   localparam int unsigned DefLw = 13;

   // Byte-strobe value for a full 32-bit word write
   localparam logic [3:0] WrStrbFull = 4'hF;

   typedef enum logic [2:0] {
      StIdle,
      StRd,
      StCap,
      StWr,
      StDone
   } state_e;

endpackage

// File: rtl/ram_copy_dma.sv
// Word-block copy engine: reads one word, captures it, writes it, repeats.
// Every output is a register loaded from the next-state decode, so the
// request seen on the RAM port always matches the state being entered.
module ram_copy_dma
   import ram_copy_dma_pkg::*;
#(
   parameter int unsigned AW = DefAw,
   parameter int unsigned LW = DefLw
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          start_i,
   input  logic [AW-1:0] src_i,
   input  logic [AW-1:0] dst_i,
   input  logic [LW-1:0] len_i,
   output logic          busy_o,
   output logic          done_o,
   output logic [3:0]    ram_wr_o,
   output logic          ram_rd_o,
   output logic [AW-1:0] ram_addr_o,
   output logic [31:0]   ram_data_o,
   input  logic [31:0]   ram_data_i,
   input  logic          ram_accept_i
);

   state_e        r_state, w_state;
   logic [AW-1:0] r_src, w_src;
   logic [AW-1:0] r_dst, w_dst;
   logic [LW-1:0] r_cnt, w_cnt;
   logic [31:0]   r_data, w_data;

   logic          w_busy, w_done, w_rd;
   logic [3:0]    w_wr;
   logic [AW-1:0] w_addr;
   logic [31:0]   w_wdata;

   // Next-state, datapath updates and next values of the registered outputs
   always_comb begin
      w_state = r_state;
      w_src   = r_src;
      w_dst   = r_dst;
      w_cnt   = r_cnt;
      w_data  = r_data;

      unique case (r_state)
         StIdle: begin
            if (start_i) begin
               w_src   = src_i;
               w_dst   = dst_i;
               w_cnt   = len_i;
               w_state = (len_i == '0) ? StDone : StRd;
            end
         end
         StRd: begin
            if (ram_accept_i) w_state = StCap;
         end
         StCap: begin
            // Read data is only valid in this one cycle
            w_data  = ram_data_i;
            w_state = StWr;
         end
         StWr: begin
            if (ram_accept_i) begin
               // Addresses wrap modulo 2^AW by plain truncation
               w_src   = r_src + AW'(1);
               w_dst   = r_dst + AW'(1);
               w_cnt   = r_cnt - LW'(1);
               w_state = (r_cnt == LW'(1)) ? StDone : StRd;
            end
         end
         StDone: begin
            w_state = StIdle;
         end
         default: begin
            w_state = StIdle;
         end
      endcase

      w_busy  = (w_state == StRd) || (w_state == StCap) || (w_state == StWr);
      w_done  = (w_state == StDone);
      w_rd    = (w_state == StRd);
      w_wr    = (w_state == StWr) ? WrStrbFull : 4'h0;
      w_addr  = '0;
      w_wdata = '0;
      if (w_state == StRd) begin
         w_addr = w_src;
      end else if (w_state == StWr) begin
         w_addr  = w_dst;
         w_wdata = w_data;
      end
   end

   // State, datapath and output registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state    <= StIdle;
         r_src      <= '0;
         r_dst      <= '0;
         r_cnt      <= '0;
         r_data     <= '0;
         busy_o     <= 1'b0;
         done_o     <= 1'b0;
         ram_rd_o   <= 1'b0;
         ram_wr_o   <= 4'h0;
         ram_addr_o <= '0;
         ram_data_o <= '0;
      end else begin
         r_state    <= w_state;
         r_src      <= w_src;
         r_dst      <= w_dst;
         r_cnt      <= w_cnt;
         r_data     <= w_data;
         busy_o     <= w_busy;
         done_o     <= w_done;
         ram_rd_o   <= w_rd;
         ram_wr_o   <= w_wr;
         ram_addr_o <= w_addr;
         ram_data_o <= w_wdata;
      end
   end

endmodule

// File: tb/tb_ram_copy_dma.sv
// Directed bench for ram_copy_dma with a behavioural word RAM beside it.
module tb_ram_copy_dma;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        start_i = 1'b0;
   logic [11:0] src_i = '0;
   logic [11:0] dst_i = '0;
   logic [12:0] len_i = '0;
   logic        busy_o, done_o, ram_rd_o;
   logic [3:0]  ram_wr_o;
   logic [11:0] ram_addr_o;
   logic [31:0] ram_data_o;
   logic [31:0] ram_data_i = '0;
   logic        ram_accept_i = 1'b1;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] mem [0:4095];
   logic        preload = 1'b0;

   // Port activity log and protocol counters, filled by the monitor
   logic [11:0] rd_log[$];
   logic [11:0] wa_log[$];
   logic [31:0] wd_log[$];
   int          conflict = 0;
   int          idle_req = 0;
   int          unstable = 0;
   int          done_cnt = 0;
   logic        p_rd = 1'b0, p_wr = 1'b0, p_acc = 1'b0;
   logic [11:0] p_addr = '0;
   logic [31:0] p_data = '0;

   ram_copy_dma dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .start_i      (start_i),
      .src_i        (src_i),
      .dst_i        (dst_i),
      .len_i        (len_i),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .ram_wr_o     (ram_wr_o),
      .ram_rd_o     (ram_rd_o),
      .ram_addr_o   (ram_addr_o),
      .ram_data_o   (ram_data_o),
      .ram_data_i   (ram_data_i),
      .ram_accept_i (ram_accept_i)
   );

   always #5 clk_i = ~clk_i;

   // Preload image: 0x010..0x013 = A0..A3, 0x100..0x7FF zero, rest tagged with address
   function automatic logic [31:0] pat(int i);
      if (i >= 'h100 && i < 'h800) return 32'h0;
      if (i >= 'h10 && i < 'h14) return 32'hA0 + 32'(i - 'h10);
      return 32'hC0DE_0000 | 32'(i);
   endfunction

   // Word RAM: registered read data, full-word writes on accept
   always @(posedge clk_i) begin
      if (preload) begin
         for (int i = 0; i < 4096; i++) mem[i] <= pat(i);
      end else begin
         if (ram_rd_o && ram_accept_i) ram_data_i <= mem[ram_addr_o];
         if (ram_wr_o == 4'hF && ram_accept_i) mem[ram_addr_o] <= ram_data_o;
      end
   end

   // Protocol monitor sampled mid-cycle
   always @(negedge clk_i) begin
      if (!rst_ni) begin
         p_rd = 1'b0;
         p_wr = 1'b0;
      end else begin
         if (ram_rd_o && ram_wr_o != 4'h0) conflict++;
         if (ram_wr_o != 4'h0 && ram_wr_o != 4'hF) conflict++;
         if ((ram_rd_o || ram_wr_o != 4'h0) && !busy_o) idle_req++;
         if (p_rd && !p_acc && !(ram_rd_o && ram_addr_o == p_addr)) unstable++;
         if (p_wr && !p_acc &&
             !(ram_wr_o == 4'hF && ram_addr_o == p_addr && ram_data_o == p_data)) unstable++;
         if (ram_rd_o && ram_accept_i) rd_log.push_back(ram_addr_o);
         if (ram_wr_o == 4'hF && ram_accept_i) begin
            wa_log.push_back(ram_addr_o);
            wd_log.push_back(ram_data_o);
         end
         if (done_o) done_cnt++;
         p_rd   = ram_rd_o;
         p_wr   = (ram_wr_o == 4'hF);
         p_acc  = ram_accept_i;
         p_addr = ram_addr_o;
         p_data = ram_data_o;
      end
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Pulses start in cycle 0, then runs until done_o or a cycle budget.
   // stall bit k drops accept in cycle k; restart_at re-pulses start with src 0x300.
   task automatic run_copy(input logic [11:0] s, input logic [11:0] d, input logic [12:0] n,
                           input logic [31:0] stall, input int restart_at,
                           output int done_cyc, output int b_first, output int b_last);
      int cyc;
      done_cyc = -1;
      b_first  = -1;
      b_last   = -1;
      src_i    = s;
      dst_i    = d;
      len_i    = n;
      start_i  = 1'b1;
      ram_accept_i = 1'b1;
      tick();
      start_i = 1'b0;
      cyc = 1;
      while (cyc < 200 && done_cyc < 0) begin
         ram_accept_i = (cyc < 32) ? ~stall[cyc] : 1'b1;
         if (cyc == restart_at) begin
            start_i = 1'b1;
            src_i   = 12'h300;
            dst_i   = 12'h310;
         end else begin
            start_i = 1'b0;
         end
         if (busy_o) begin
            if (b_first < 0) b_first = cyc;
            b_last = cyc;
         end
         if (done_o) done_cyc = cyc;
         tick();
         cyc++;
      end
      start_i = 1'b0;
      ram_accept_i = 1'b1;
   endtask

   initial begin
      int dc, bf, bl, base_rd, base_wr, dn;

      // Reset and preload
      #2;
      preload = 1'b1;
      tick();
      tick();
      preload = 1'b0;
      chk("reset_outputs", {7'd0, busy_o, done_o, ram_rd_o, ram_wr_o, ram_addr_o}, 32'h0);
      chk("reset_wdata", ram_data_o, 32'h0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      tick();

      // Basic 4-word copy with accept tied high
      run_copy(12'h010, 12'h100, 13'd4, 32'h0, -1, dc, bf, bl);
      chk("basic_done_cycle", dc, 13);
      chk("basic_busy_first", bf, 1);
      chk("basic_busy_last", bl, 12);
      chk("basic_mem0", mem['h100], 32'hA0);
      chk("basic_mem1", mem['h101], 32'hA1);
      chk("basic_mem2", mem['h102], 32'hA2);
      chk("basic_mem3", mem['h103], 32'hA3);
      tick();

      // Zero-length copy: immediate done, no bus traffic
      base_rd = rd_log.size();
      base_wr = wa_log.size();
      run_copy(12'h010, 12'h180, 13'd0, 32'h0, -1, dc, bf, bl);
      chk("len0_done_cycle", dc, 1);
      chk("len0_busy_never", bf, -1);
      chk("len0_no_reads", rd_log.size() - base_rd, 0);
      chk("len0_no_writes", wa_log.size() - base_wr, 0);
      tick();

      // Stalls: 3 cycles in first RD, 2 in first WR; done moves from 4 to 9
      base_wr = wa_log.size();
      run_copy(12'h012, 12'h600, 13'd1, 32'h0000_00CE, -1, dc, bf, bl);
      chk("stall_done_cycle", dc, 9);
      chk("stall_wdata", (wd_log.size() > base_wr) ? wd_log[base_wr] : 32'hDEAD, 32'hA2);
      chk("stall_mem", mem['h600], 32'hA2);
      chk("stall_held_stable", unstable, 0);
      tick();

      // Address wrap on source side
      base_rd = rd_log.size();
      run_copy(12'hFFE, 12'h7FE, 13'd4, 32'h0, -1, dc, bf, bl);
      chk("wrap_done_cycle", dc, 13);
      chk("wrap_nreads", rd_log.size() - base_rd, 4);
      if (rd_log.size() - base_rd == 4) begin
         chk("wrap_rd0", rd_log[base_rd],     12'hFFE);
         chk("wrap_rd1", rd_log[base_rd + 1], 12'hFFF);
         chk("wrap_rd2", rd_log[base_rd + 2], 12'h000);
         chk("wrap_rd3", rd_log[base_rd + 3], 12'h001);
      end
      chk("wrap_mem0", mem['h7FE], 32'hC0DE_0FFE);
      chk("wrap_mem1", mem['h7FF], 32'hC0DE_0FFF);
      chk("wrap_mem2", mem['h800], 32'hC0DE_0000);
      chk("wrap_mem3", mem['h801], 32'hC0DE_0001);
      tick();

      // Start pulsed mid-copy is ignored
      base_rd = rd_log.size();
      run_copy(12'h010, 12'h200, 13'd4, 32'h0, 5, dc, bf, bl);
      chk("restart_done_cycle", dc, 13);
      chk("restart_rd_last", (rd_log.size() - base_rd == 4) ? rd_log[base_rd + 3] : 12'hBAD,
          12'h013);
      chk("restart_mem0", mem['h200], 32'hA0);
      chk("restart_mem3", mem['h203], 32'hA3);
      chk("restart_untouched", mem['h310], 32'h0);
      tick();
      tick();

      // Reset during the WR of word 2 (cycle 6)
      dn = done_cnt;
      src_i   = 12'h010;
      dst_i   = 12'h400;
      len_i   = 13'd4;
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      for (int k = 0; k < 5; k++) tick();
      chk("abort_in_wr", {16'd0, ram_wr_o, ram_addr_o}, {16'd0, 4'hF, 12'h401});
      #2;
      rst_ni = 1'b0;
      #1;
      chk("abort_outputs", {7'd0, busy_o, done_o, ram_rd_o, ram_wr_o, ram_addr_o}, 32'h0);
      chk("abort_wdata", ram_data_o, 32'h0);
      tick();
      tick();
      @(negedge clk_i);
      rst_ni = 1'b1;
      tick();
      tick();
      chk("abort_no_done", done_cnt - dn, 0);
      chk("abort_word1", mem['h400], 32'hA0);
      chk("abort_word2", mem['h401], 32'h0);
      chk("abort_word4", mem['h403], 32'h0);

      // Normal operation after reset
      run_copy(12'h011, 12'h500, 13'd1, 32'h0, -1, dc, bf, bl);
      chk("post_reset_done", dc, 4);
      tick();
      chk("post_reset_mem", mem['h500], 32'hA1);

      // Protocol invariants over the whole run
      chk("no_rd_wr_overlap", conflict, 0);
      chk("no_req_when_idle", idle_req, 0);
      chk("stall_stability_all", unstable, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
